encdec_arbiter: RTL and testbench
=================================

# encdec_arbiter

Two-channel arbiter and sequencer for the shared keyed add/subtract-mod-128 cipher datapath. An encrypt requester and a decrypt requester compete for the one datapath. The block grants one request at a time with round-robin fairness, latches that request's byte and key, and computes the mod-128 result. It presents the result on a single output port with valid/ready backpressure. It sits between the byte-stream front ends and the downstream result consumer.

## Interface
- DATA_W, 8, request/result byte width
- KEY_W, 3, key width
- MOD_BITS, 7, modulus exponent (modulus = 2^MOD_BITS = 128)

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- enc_req  in  1  encrypt request; held high with enc_data stable until enc_ack
- enc_data  in  DATA_W  encrypt plaintext byte
- enc_ack  out  1  one-cycle pulse: enc request accepted
- dec_req  in  1  decrypt request; held high with dec_data stable until dec_ack
- dec_data  in  DATA_W  decrypt ciphertext byte
- dec_ack  out  1  one-cycle pulse: dec request accepted
- key  in  KEY_W  shared key, sampled at grant
- out_data  out  DATA_W  result; bit 7 always 0
- out_chan  out  1  0 = encrypt result, 1 = decrypt result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result when out_valid && out_ready

## Operation
- FSM states:
  - IDLE: wait for a request.
  - CALC: compute the result.
  - HOLD: present the result.
- IDLE:
  - If either req is high at the clock edge, grant one requester.
  - Both high: grant the channel that was not served last. After reset, encrypt wins.
  - On grant, latch data, key and channel, and pulse the matching ack in the next cycle.
  - Go to CALC.
- CALC:
  - Encrypt: result = (data + key) mod 128.
  - Decrypt: result = (data − key) mod 128.
  - Arithmetic is done at DATA_W+1 bits two's complement; keep the low MOD_BITS bits and zero-extend to DATA_W.
  - A negative difference wraps; for example 2 − 5 gives 0x7D.
  - Register the result into out_data, set out_valid, and go to HOLD.
- HOLD:
  - out_data, out_chan and out_valid stay stable until out_ready is seen.
  - On out_valid && out_ready: clear out_valid, set last-served = out_chan, and go to IDLE.
- Inputs with data = 0 and key = 0 are processed normally. They produce result 0x00.
- A requester that keeps req high after its ack is treated as issuing a new request. It is eligible again in the next IDLE visit.
- Changes to key after grant do not affect the transaction in flight.
- Requests that arrive during CALC or HOLD are not acked. They wait.

## Timing
- Reset values:
  - state = IDLE
  - enc_ack = dec_ack = 0
  - out_valid = 0
  - out_data = 0x00
  - out_chan = 0
  - last-served = decrypt, so encrypt has first priority
- Reset asserted mid-transaction:
  - The in-flight result is discarded and no ack is reissued.
  - In the cycle after the reset edge, every output is at its reset value.
- Latency: request sampled in IDLE at edge N; ack high in cycle N+1; out_valid high from cycle N+2.
- Throughput: with out_ready held high, one result every 3 cycles.
- Every grant produces exactly one ack pulse and exactly one result.
- Acks are never both high in the same cycle.
- When out_ready is low in HOLD, the block stalls indefinitely and no new grant is made.

## Structure
- Package encdec_pkg holds:
  - the state enum (IDLE, CALC, HOLD)
  - the channel encoding constants CH_ENC = 0 and CH_DEC = 1
  - MOD_BITS
- Sub-module encdec_mod_unit: combinational add/sub mod 2^MOD_BITS.
  - Inputs: data, key, op.
  - Output: result.
  - It is instantiated once; the arbiter FSM drives it from the latched registers.

## Test plan
- After reset, enc_req with enc_data = 0x05 and key = 3, out_ready = 1:
  - enc_ack pulses in cycle 1.
  - out_valid rises in cycle 2 with out_data = 0x08 and out_chan = 0.
- Decrypt wrap-around: dec_data = 0x02, key = 5 → out_data = 0x7D, out_chan = 1.
- Encrypt overflow:
  - enc_data = 0x7E, key = 4 → 0x02.
  - enc_data = 0xFF, key = 1 → 0x00.
- Simultaneous requests held continuously after reset:
  - Grants alternate enc, dec, enc, dec.
  - Each ack is a single-cycle pulse.
  - Results come out in grant order.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in HOLD.
  - out_data and out_valid stay stable and no ack is issued.
  - Raise out_ready: the transfer completes and the FSM returns to IDLE the next cycle.
- Assert RST during CALC:
  - The next cycle shows out_valid = 0 and no result is produced.
  - A following encrypt request (0x10, key = 7) yields 0x17 with encrypt priority.

Source files
------------

// File: rtl/encdec_pkg.sv
// Shared types and constants for the two-channel keyed mod-128 cipher arbiter.
// Holds the FSM state encoding, channel codes and the round-robin pick rule.
package encdec_pkg;

    localparam int MOD_BITS = 7;

    localparam logic CH_ENC = 1'b0;
    localparam logic CH_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    // Round-robin pick: on a tie the channel not served last wins.
    function automatic logic pick_channel(input logic enc_req,
                                          input logic dec_req,
                                          input logic last_served);
        if (enc_req && dec_req) begin
            return ~last_served;
        end else if (dec_req) begin
            return CH_DEC;
        end else begin
            return CH_ENC;
        end
    endfunction

endpackage

// File: rtl/encdec_mod_unit.sv
// Combinational keyed add/subtract modulo 2^MOD_BITS, zero-extended to DATA_W.
// Arithmetic runs at DATA_W+1 bits so a negative difference wraps naturally.
module encdec_mod_unit #(
    parameter int DATA_W = 8,
    parameter int KEY_W  = 3
) (
    input  logic [DATA_W-1:0] data,
    input  logic [KEY_W-1:0]  key,
    input  logic              op,
    output logic [DATA_W-1:0] result
);
    import encdec_pkg::*;

    logic [DATA_W:0] data_ext;
    logic [DATA_W:0] key_ext;
    logic [DATA_W:0] raw;
    logic            unused_hi;

    assign data_ext = {1'b0, data};
    assign key_ext  = {{(DATA_W + 1 - KEY_W){1'b0}}, key};
    assign raw      = (op == CH_DEC) ? (data_ext - key_ext) : (data_ext + key_ext);

    // Only the low MOD_BITS survive the modulus; the upper bits are discarded.
    assign result    = {{(DATA_W - MOD_BITS){1'b0}}, raw[MOD_BITS-1:0]};
    assign unused_hi = ^raw[DATA_W:MOD_BITS];

endmodule

// File: rtl/encdec_arbiter.sv
// Round-robin arbiter/sequencer for the shared keyed mod-128 datapath: grants one
// of the encrypt/decrypt requesters, computes the result, and holds it under valid/ready.
module encdec_arbiter #(
    parameter int DATA_W = 8,
    parameter int KEY_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enc_req,
    input  logic [DATA_W-1:0] enc_data,
    output logic              enc_ack,
    input  logic              dec_req,
    input  logic [DATA_W-1:0] dec_data,
    output logic              dec_ack,
    input  logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] out_data,
    output logic              out_chan,
    output logic              out_valid,
    input  logic              out_ready
);
    import encdec_pkg::*;

    state_t            state;
    logic              last_served;
    logic              chan_q;
    logic [DATA_W-1:0] data_q;
    logic [KEY_W-1:0]  key_q;
    logic [DATA_W-1:0] mod_result;
    logic              grant_chan;

    assign grant_chan = pick_channel(enc_req, dec_req, last_served);

    // The datapath only ever sees latched operands, so late key changes are harmless.
    encdec_mod_unit #(
        .DATA_W (DATA_W),
        .KEY_W  (KEY_W)
    ) u_mod (
        .data   (data_q),
        .key    (key_q),
        .op     (chan_q),
        .result (mod_result)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
    // a blocking (=) would let later statements see this cycle's new value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            enc_ack     <= 1'b0;
            dec_ack     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_chan    <= CH_ENC;
            last_served <= CH_DEC;
            chan_q      <= CH_ENC;
            data_q      <= '0;
            key_q       <= '0;
        end else begin
            // NOTE: acks default low each cycle so a grant yields exactly one pulse.
            enc_ack <= 1'b0;
            dec_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (enc_req || dec_req) begin
                        chan_q  <= grant_chan;
                        data_q  <= (grant_chan == CH_DEC) ? dec_data : enc_data;
                        key_q   <= key;
                        enc_ack <= (grant_chan == CH_ENC);
                        dec_ack <= (grant_chan == CH_DEC);
                        state   <= CALC;
                    end
                end

                CALC: begin
                    out_data  <= mod_result;
                    out_chan  <= chan_q;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end

                HOLD: begin
                    // Fairness history only advances once the result is actually consumed.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        last_served <= out_chan;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encdec_arbiter.sv
// Directed self-checking bench for encdec_arbiter: latency, wrap-around, round-robin,
// backpressure and mid-transaction reset, with hand-computed expected values.
module tb_encdec_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enc_req;
    logic [7:0] enc_data;
    logic       enc_ack;
    logic       dec_req;
    logic [7:0] dec_data;
    logic       dec_ack;
    logic [2:0] key;
    logic [7:0] out_data;
    logic       out_chan;
    logic       out_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    encdec_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .enc_req   (enc_req),
        .enc_data  (enc_data),
        .enc_ack   (enc_ack),
        .dec_req   (dec_req),
        .dec_data  (dec_data),
        .dec_ack   (dec_ack),
        .key       (key),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST       = 1'b1;
        enc_req   = 1'b0;
        dec_req   = 1'b0;
        enc_data  = 8'h00;
        dec_data  = 8'h00;
        key       = 3'd0;
        out_ready = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Drives one request through grant and result with bounded waits; returns the result.
    task automatic run_txn(input logic is_dec, input logic [7:0] d, input logic [2:0] k,
                           output logic [7:0] got_data, output logic got_chan,
                           output logic ok);
        logic seen;
        ok       = 1'b1;
        got_data = 8'h00;
        got_chan = 1'b0;
        key      = k;
        if (is_dec) begin
            dec_data = d;
            dec_req  = 1'b1;
        end else begin
            enc_data = d;
            enc_req  = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = is_dec ? dec_ack : enc_ack;
        end
        enc_req = 1'b0;
        dec_req = 1'b0;
        key     = ~k;
        if (!seen) ok = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = out_valid;
        end
        if (!seen) ok = 1'b0;
        got_data = out_data;
        got_chan = out_chan;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({enc_ack, dec_ack} !== 2'b00) begin
            failures++;
            $display("FAIL reset_acks: got %b expected 00", {enc_ack, dec_ack});
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({out_chan, out_data} !== 9'h000) begin
            failures++;
            $display("FAIL reset_out: got chan=%b data=%h expected chan=0 data=00", out_chan, out_data);
        end
    endtask

    task automatic test_first_encrypt();
        enc_data = 8'h05;
        key      = 3'd3;
        enc_req  = 1'b1;
        tick();
        checks++;
        if ({enc_ack, dec_ack, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL first_enc_cycle1: got ack/dack/valid=%b expected 100", {enc_ack, dec_ack, out_valid});
        end
        enc_req = 1'b0;
        tick();
        checks++;
        if ({enc_ack, out_valid, out_chan, out_data} !== {1'b0, 1'b1, 1'b0, 8'h08}) begin
            failures++;
            $display("FAIL first_enc_cycle2: got ack=%b valid=%b chan=%b data=%h expected 0 1 0 08",
                     enc_ack, out_valid, out_chan, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_enc_done: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_arith();
        logic [7:0] vec_data [6] = '{8'h02, 8'h7E, 8'hFF, 8'h00, 8'h80, 8'h35};
        logic [2:0] vec_key  [6] = '{3'd5, 3'd4, 3'd1, 3'd0, 3'd1, 3'd7};
        logic       vec_dec  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] vec_exp  [6] = '{8'h7D, 8'h02, 8'h00, 8'h00, 8'h7F, 8'h2E};
        logic [7:0] got_d;
        logic       got_c;
        logic       ok;
        for (int i = 0; i < 6; i++) begin
            run_txn(vec_dec[i], vec_data[i], vec_key[i], got_d, got_c, ok);
            checks++;
            if (!ok || got_d !== vec_exp[i] || got_c !== vec_dec[i]) begin
                failures++;
                $display("FAIL arith_%0d: got ok=%b data=%h chan=%b expected ok=1 data=%h chan=%b",
                         i, ok, got_d, got_c, vec_exp[i], vec_dec[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] got;
        logic [11:0] exp;
        apply_reset();
        enc_data = 8'h11;
        dec_data = 8'h22;
        key      = 3'd2;
        enc_req  = 1'b1;
        dec_req  = 1'b1;
        // Grants at cycles 1,4,7,10 alternate enc/dec; results at 2,5,8,11.
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp = {(c % 6 == 1), (c % 6 == 4), (c % 3 == 2), 9'h000};
            if (c % 3 == 2) exp[8:0] = (c % 6 == 5) ? {1'b1, 8'h20} : {1'b0, 8'h13};
            got = {enc_ack, dec_ack, out_valid, (out_valid ? {out_chan, out_data} : 9'h000)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got ack/dack/valid/chan/data=%h expected %h", c, got, exp);
            end
        end
        enc_req = 1'b0;
        dec_req = 1'b0;
        tick();
        checks++;
        if ({enc_ack, dec_ack, out_valid} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_quiet: got %b expected 000", {enc_ack, dec_ack, out_valid});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        enc_data  = 8'h30;
        key       = 3'd1;
        enc_req   = 1'b1;
        tick();
        checks++;
        if (enc_ack !== 1'b1) begin
            failures++;
            $display("FAIL bp_ack: got %b expected 1", enc_ack);
        end
        enc_req  = 1'b0;
        dec_data = 8'h40;
        dec_req  = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({enc_ack, dec_ack, out_valid, out_chan, out_data} !== {4'b0010, 8'h31}) begin
                failures++;
                $display("FAIL bp_stall%0d: got ack=%b dack=%b valid=%b chan=%b data=%h expected 0 0 1 0 31",
                         i, enc_ack, dec_ack, out_valid, out_chan, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tick();
        checks++;
        if ({out_valid, dec_ack} !== 2'b00) begin
            failures++;
            $display("FAIL bp_release: got valid=%b dack=%b expected 0 0", out_valid, dec_ack);
        end
        tick();
        checks++;
        if (dec_ack !== 1'b1) begin
            failures++;
            $display("FAIL bp_next_grant: got dack=%b expected 1", dec_ack);
        end
        dec_req = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_chan, out_data} !== {2'b11, 8'h3F}) begin
            failures++;
            $display("FAIL bp_dec_result: got valid=%b chan=%b data=%h expected 1 1 3f",
                     out_valid, out_chan, out_data);
        end
        tick();
    endtask

    task automatic test_reset_calc();
        logic [7:0] got_d;
        logic       got_c;
        logic       ok;
        // Leave last-served = encrypt so only the reset can restore encrypt priority.
        run_txn(1'b0, 8'h01, 3'd1, got_d, got_c, ok);
        enc_data = 8'h50;
        key      = 3'd1;
        enc_req  = 1'b1;
        tick();
        enc_req = 1'b0;
        RST     = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({enc_ack, dec_ack, out_valid, out_chan, out_data} !== 12'h000) begin
            failures++;
            $display("FAIL rst_calc_outputs: got ack=%b dack=%b valid=%b chan=%b data=%h expected all 0",
                     enc_ack, dec_ack, out_valid, out_chan, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({enc_ack, out_valid} !== 2'b00) begin
                failures++;
                $display("FAIL rst_calc_quiet%0d: got ack=%b valid=%b expected 0 0", i, enc_ack, out_valid);
            end
        end
        enc_data = 8'h10;
        dec_data = 8'h20;
        key      = 3'd7;
        enc_req  = 1'b1;
        dec_req  = 1'b1;
        tick();
        checks++;
        if ({enc_ack, dec_ack} !== 2'b10) begin
            failures++;
            $display("FAIL rst_priority: got ack/dack=%b expected 10", {enc_ack, dec_ack});
        end
        enc_req = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_chan, out_data} !== {2'b10, 8'h17}) begin
            failures++;
            $display("FAIL rst_enc_result: got valid=%b chan=%b data=%h expected 1 0 17",
                     out_valid, out_chan, out_data);
        end
        tick();
        tick();
        checks++;
        if (dec_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_dec_grant: got dack=%b expected 1", dec_ack);
        end
        dec_req = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_chan, out_data} !== {2'b11, 8'h19}) begin
            failures++;
            $display("FAIL rst_dec_result: got valid=%b chan=%b data=%h expected 1 1 19",
                     out_valid, out_chan, out_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_first_encrypt();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
